sme_match_collector: RTL

- Downstream stage of the string-matching engine (SME).
- Captures each match report (pattern_no, match_addr) that SME flags with valid, and queues it in a FIFO.
- Drains the queue to the host over a valid/ready handshake, keeps a saturating match count per pattern, and raises done once SME has finished and the queue is empty.

---
 rtl/sme_match_collector_if.sv | 28 ++
 rtl/sme_match_collector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sme_match_collector_if.sv
// SME match-collector bus: SME match strobe/finish, host head-of-queue handshake,
// and per-pattern counter readback. The master side drives, the collector is the slave.
interface sme_match_collector_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       pattern_no;
    logic [11:0]      match_addr;
    logic             valid;
    logic             finish;
    logic [3:0]       out_pattern_no;
    logic [11:0]      out_match_addr;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       count_sel;
    logic [CNT_W-1:0] count_value;
    logic             overflow;
    logic             done;

    modport master (
        output pattern_no, match_addr, valid, finish, out_ready, count_sel,
        input  out_pattern_no, out_match_addr, out_valid, count_value, overflow, done
    );

    modport slave (
        input  pattern_no, match_addr, valid, finish, out_ready, count_sel,
        output out_pattern_no, out_match_addr, out_valid, count_value, overflow, done
    );
endinterface

// File: rtl/sme_match_collector.sv
// Collects SME match reports into a first-word-fall-through FIFO, counts matches per pattern
// and flags done after finish once the queue has drained. Define SME_DEDUP_EN to absorb repeats.
module sme_match_collector #(
    parameter int DEPTH   = 16,
    parameter int PAT_NUM = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sme_match_collector_if.slave  bus
);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_collect_en;
    logic             w_done_nxt;
    logic             r_done;
    logic             r_overflow;

    logic [15:0]      r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_wr_ptr_nxt;
    logic [AW:0]      w_rd_ptr_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_empty_nxt;
    logic [15:0]      w_entry;
    logic [15:0]      w_head;
    logic             w_pop;
    logic             w_dup;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;

    logic [CNT_W-1:0] r_cnt [PAT_NUM];
    logic [CNT_W-1:0] w_cnt_nxt [PAT_NUM];
    logic [CNT_W-1:0] w_cnt_sel;
    logic [CNT_W-1:0] r_count_value;

    assign w_entry      = {bus.pattern_no, bus.match_addr};
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop        = !w_empty && bus.out_ready;
    assign w_push_req   = bus.valid && w_collect_en && !w_dup;
    // A full FIFO still takes the new entry when the head leaves on the same edge.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_drop       = w_push_req && w_full && !w_pop;
    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);

`ifdef SME_DEDUP_EN
    logic [15:0] r_last_entry;
    logic        r_last_ok;

    assign w_dup = bus.valid && r_last_ok && (w_entry == r_last_entry);

    // Remember the last accepted report so a held strobe is pushed only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_entry <= 16'd0;
            r_last_ok    <= 1'b0;
        end else if (w_push) begin
            r_last_entry <= w_entry;
            r_last_ok    <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: w_state_nxt = bus.finish  ? ST_DRAIN : ST_COLLECT;
            ST_DRAIN:   w_state_nxt = w_empty_nxt ? ST_DONE  : ST_DRAIN;
            ST_DONE:    w_state_nxt = ST_DONE;
            default:    w_state_nxt = ST_COLLECT;
        endcase
    end

    // FSM outputs: pushes only while collecting, done tracks entry into DONE.
    always_comb begin
        w_collect_en = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_COLLECT: w_collect_en = 1'b1;
            ST_DRAIN:   w_collect_en = 1'b0;
            ST_DONE:    w_collect_en = 1'b0;
            default:    w_collect_en = 1'b0;
        endcase
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // FIFO storage; contents need no reset because the empty flag masks the head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    // Pointers, sticky overflow and done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= {(AW+1){1'b0}};
            r_rd_ptr   <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_overflow <= r_overflow || w_drop;
            r_done     <= w_done_nxt;
        end
    end

    // Saturating per-pattern increments and the readback mux over the post-edge values.
    always_comb begin
        w_cnt_sel = CNT_ZERO;
        for (int i = 0; i < PAT_NUM; i++) begin
            w_cnt_nxt[i] = (w_push && ({28'd0, bus.pattern_no} == i) && (r_cnt[i] != CNT_MAX))
                         ? (r_cnt[i] + CNT_ONE) : r_cnt[i];
            w_cnt_sel    = w_cnt_sel |
                           (({28'd0, bus.count_sel} == i) ? w_cnt_nxt[i] : CNT_ZERO);
        end
    end

    // Counter bank and registered counter readback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PAT_NUM; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
            r_count_value <= CNT_ZERO;
        end else begin
            for (int i = 0; i < PAT_NUM; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_count_value <= w_cnt_sel;
        end
    end

    assign bus.out_valid      = !w_empty;
    assign bus.out_pattern_no = w_empty ? 4'd0  : w_head[15:12];
    assign bus.out_match_addr = w_empty ? 12'd0 : w_head[11:0];
    assign bus.count_value    = r_count_value;
    assign bus.overflow       = r_overflow;
    assign bus.done           = r_done;

endmodule
